// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC8 result write-back path.
package mac_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } wr_state_t;

    localparam int         MEM_WORD_WIDTH = 64;
    localparam logic [7:0] MEM_BE_ALL     = 8'hFF;

endpackage

// File: rtl/mac_result_writer_if.sv
// Avalon-MM write-master bundle between the result writer and mem_wrapper.
interface mac_result_writer_if;
    import mac_pkg::*;

    logic [31:0]               avm_address;
    logic                      avm_write;
    logic [MEM_WORD_WIDTH-1:0] avm_writedata;
    logic [7:0]                avm_byteenable;
    logic                      avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        output avm_waitrequest
    );

endinterface

// File: rtl/mac_result_writer.sv
// Snapshots the N MAC8 lane results on start and writes them, zero-extended,
// to consecutive memory words through an Avalon-MM write master.
module mac_result_writer
    import mac_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          N          = 8,
    parameter int          RES_WIDTH  = 3 * DATA_WIDTH,
    parameter int unsigned BASE_ADDR  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [RES_WIDTH-1:0]     c_in [0:N-1],
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N+1)-1:0]   words_written,
    mac_result_writer_if.master      avm
);

    localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
    localparam int WW_W   = $clog2(N + 1);

    wr_state_t                 r_state;
    logic [RES_WIDTH-1:0]      r_snap [0:N-1];
    logic [LANE_W-1:0]         r_lane;
    logic [WW_W-1:0]           r_words;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_write;
    logic [31:0]               r_addr;
    logic [MEM_WORD_WIDTH-1:0] r_data;
    logic [7:0]                r_be;

    logic [LANE_W-1:0]         w_next_lane;
    logic                      w_accept;
    logic                      w_last;

    // Lane results are unsigned, so widening never sign-extends.
    function automatic logic [MEM_WORD_WIDTH-1:0] zext(input logic [RES_WIDTH-1:0] v);
        return MEM_WORD_WIDTH'(v);
    endfunction

    assign w_next_lane = r_lane + LANE_W'(1);
    assign w_accept    = r_write && !avm.avm_waitrequest;
    assign w_last      = (r_lane == LANE_W'(N - 1));

    // Capture/write sequencer; every output comes straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            for (int i = 0; i < N; i++) begin
                r_snap[i] <= '0;
            end
            r_lane  <= '0;
            r_words <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_data  <= '0;
            r_be    <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_snap  <= c_in;
                        r_lane  <= '0;
                        r_words <= '0;
                        r_busy  <= 1'b1;
                        r_write <= 1'b1;
                        r_addr  <= 32'(BASE_ADDR);
                        r_data  <= zext(c_in[0]);
                        r_be    <= MEM_BE_ALL;
                        r_state <= S_WRITE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_write <= 1'b0;
                        r_be    <= 8'h00;
                    end
                end
                S_WRITE: begin
                    // A stalled write simply keeps address/data/write as they are.
                    if (w_accept) begin
                        r_words <= r_words + WW_W'(1);
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_write <= 1'b0;
                            r_addr  <= 32'd0;
                            r_data  <= '0;
                            r_be    <= 8'h00;
                            r_state <= S_DONE;
                        end else begin
                            r_lane  <= w_next_lane;
                            r_addr  <= 32'(BASE_ADDR) + 32'(w_next_lane);
                            r_data  <= zext(r_snap[w_next_lane]);
                        end
                    end else begin
                        r_state <= S_WRITE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_write <= 1'b0;
                    r_be    <= 8'h00;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy               = r_busy;
    assign done               = r_done;
    assign words_written      = r_words;
    assign avm.avm_address    = r_addr;
    assign avm.avm_write      = r_write;
    assign avm.avm_writedata  = r_data;
    assign avm.avm_byteenable = r_be;

endmodule
